// File: rtl/pc_bpu.sv
// Fetch PC generator with a small fully-associative 2-bit branch predictor table.
// Optional build macro PC_BPU_BTFN_EN: backward-taken/forward-not-taken prediction on table misses.
module pc_bpu #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        ENTRIES  = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [1:0]         CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        jump_cause_i,
    input  logic [ADDR_W-1:0] jump_to_addr_i,
    input  logic              hold_i,
    input  logic [31:0]       inst_i,
    input  logic              resolve_valid_i,
    input  logic [ADDR_W-1:0] resolve_addr_i,
    input  logic              resolve_taken_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] now_pc_o,
    output logic              predict_to_jump_o
);

    localparam int unsigned IDX_W      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned IMM_W      = 13;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [2:0]  CAUSE_NONE = 3'd0;
    localparam logic [2:0]  CAUSE_IRQ  = 3'd4;
    localparam logic [2:0]  CAUSE_EXC  = 3'd5;
    localparam logic [1:0]  CNT_MAX    = 2'b11;
    localparam logic [1:0]  CNT_MIN    = 2'b00;
`ifdef PC_BPU_BTFN_EN
    localparam logic [1:0]  CNT_BACKWARD = 2'b10;
`endif

    logic [ADDR_W-1:0]              pc_q, pc_d;
    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [ENTRIES-1:0][ADDR_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]               wr_ptr_q, wr_ptr_d;

    logic              is_branch;
    logic [IMM_W-1:0]  imm_b;
    logic [ADDR_W-1:0] target;
    logic              fetch_hit;
    logic [IDX_W-1:0]  fetch_idx;
    logic              res_hit;
    logic [IDX_W-1:0]  res_idx;
    logic              alloc;
    logic [1:0]        alloc_cnt;
    logic              predict;
    logic              flush;

    // Bits of the instruction that play no part in branch decode.
    logic unused_inst;
    assign unused_inst = ^inst_i[24:12];

    assign is_branch = (inst_i[6:0] == OPC_BRANCH);
    assign imm_b     = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign target    = pc_q + ADDR_W'(signed'(imm_b));
    assign flush     = (jump_cause_i == CAUSE_IRQ) || (jump_cause_i == CAUSE_EXC);

    // Parallel tag match for the fetch PC and the resolving branch; lowest index wins.
    always_comb begin
        fetch_hit = 1'b0;
        fetch_idx = '0;
        res_hit   = 1'b0;
        res_idx   = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (!fetch_hit && valid_q[i] && (tag_q[i] == pc_q)) begin
                fetch_hit = 1'b1;
                fetch_idx = IDX_W'(i);
            end
            if (!res_hit && valid_q[i] && (tag_q[i] == resolve_addr_i)) begin
                res_hit = 1'b1;
                res_idx = IDX_W'(i);
            end
        end
    end

    // Next fetch address selection and allocation request.
    always_comb begin
        pc_d      = pc_q + ADDR_W'(4);
        predict   = 1'b0;
        alloc     = 1'b0;
        alloc_cnt = CNT_INIT;
        if (rst) begin
            pc_d = RESET_PC;
        end else if (jump_cause_i != CAUSE_NONE) begin
            pc_d = jump_to_addr_i;
        end else if (hold_i) begin
            pc_d = pc_q;
        end else if (is_branch) begin
            if (fetch_hit) begin
                if (cnt_q[fetch_idx][1]) begin
                    pc_d    = target;
                    predict = 1'b1;
                end
            end else begin
                alloc = 1'b1;
`ifdef PC_BPU_BTFN_EN
                if (imm_b[IMM_W-1]) begin
                    pc_d      = target;
                    predict   = 1'b1;
                    alloc_cnt = CNT_BACKWARD;
                end
`endif
            end
        end
    end

    // Table update: training, then allocation (wins on the same slot), then flush (wins over all).
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        if (resolve_valid_i && res_hit) begin
            if (resolve_taken_i) begin
                if (cnt_q[res_idx] != CNT_MAX) begin
                    cnt_d[res_idx] = cnt_q[res_idx] + 2'd1;
                end
            end else if (cnt_q[res_idx] != CNT_MIN) begin
                cnt_d[res_idx] = cnt_q[res_idx] - 2'd1;
            end
        end
        if (alloc) begin
            valid_d[wr_ptr_q] = 1'b1;
            tag_d[wr_ptr_q]   = pc_q;
            cnt_d[wr_ptr_q]   = alloc_cnt;
            wr_ptr_d          = wr_ptr_q + IDX_W'(1);
        end
        if (flush) begin
            valid_d  = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            valid_q  <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload fields are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end

    assign pc_o              = pc_d;
    assign now_pc_o          = rst ? RESET_PC : pc_q;
    assign predict_to_jump_o = predict;

endmodule

// File: tb/tb_pc_bpu.sv
// Testbench for pc_bpu: directed literal checks, then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_pc_bpu;

    localparam int unsigned ENTRIES  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [1:0]  CNT_INIT = 2'b01;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BEQ_P20  = 32'h0200_0063;
    localparam logic [31:0] BNE_M8   = 32'hFE00_1CE3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cause = 3'd0;
    logic [31:0] jump_to = 32'h0;
    logic        hold = 1'b0;
    logic [31:0] inst = NOP;
    logic        res_v = 1'b0;
    logic [31:0] res_a = 32'h0;
    logic        res_t = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] now_pc_o;
    logic        pred_o;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Behavioural model state: slots filled round-robin, counters as plain integers.
    logic [31:0] m_pc = RESET_PC;
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int          m_wp = 0;

    pc_bpu #(
        .ADDR_W   (32),
        .ENTRIES  (ENTRIES),
        .RESET_PC (RESET_PC),
        .CNT_INIT (CNT_INIT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .jump_cause_i      (cause),
        .jump_to_addr_i    (jump_to),
        .hold_i            (hold),
        .inst_i            (inst),
        .resolve_valid_i   (res_v),
        .resolve_addr_i    (res_a),
        .resolve_taken_i   (res_t),
        .pc_o              (pc_o),
        .now_pc_o          (now_pc_o),
        .predict_to_jump_o (pred_o)
    );

    always #5 clk = ~clk;

    function automatic int find(input logic [31:0] a);
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (m_valid[i] && m_tag[i] == a) return i;
        end
        return -1;
    endfunction

    // Expected fetch decision for the current model state and inputs (reset handled by callers).
    function automatic void model_fetch(output logic [31:0] npc, output bit pred,
                                        output bit alloc, output int acnt);
        logic [12:0] ib;
        int          imm;
        int          slot;
        ib  = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm = int'(ib);
        if (imm >= 4096) imm = imm - 8192;
        npc   = m_pc + 32'd4;
        pred  = 1'b0;
        alloc = 1'b0;
        acnt  = int'(CNT_INIT);
        if (cause != 3'd0) begin
            npc = jump_to;
        end else if (hold) begin
            npc = m_pc;
        end else if (inst[6:0] == 7'h63) begin
            slot = find(m_pc);
            if (slot >= 0) begin
                if (m_cnt[slot] >= 2) begin
                    npc  = m_pc + 32'(imm);
                    pred = 1'b1;
                end
            end else begin
                alloc = 1'b1;
`ifdef PC_BPU_BTFN_EN
                if (imm < 0) begin
                    npc  = m_pc + 32'(imm);
                    pred = 1'b1;
                    acnt = 2;
                end
`endif
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model state advance on every active edge.
    initial forever begin
        @(posedge clk);
        begin
            logic [31:0] npc;
            bit          pred;
            bit          alloc;
            int          acnt;
            int          h;
            if (rst) begin
                m_pc = RESET_PC;
                for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
                m_wp = 0;
            end else begin
                model_fetch(npc, pred, alloc, acnt);
                if (res_v) begin
                    h = find(res_a);
                    if (h >= 0) begin
                        if (res_t) m_cnt[h] = (m_cnt[h] < 3) ? m_cnt[h] + 1 : 3;
                        else       m_cnt[h] = (m_cnt[h] > 0) ? m_cnt[h] - 1 : 0;
                    end
                end
                if (alloc) begin
                    m_valid[m_wp] = 1'b1;
                    m_tag[m_wp]   = m_pc;
                    m_cnt[m_wp]   = acnt;
                    m_wp          = (m_wp + 1) % int'(ENTRIES);
                end
                if (cause == 3'd4 || cause == 3'd5) begin
                    for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
                    m_wp = 0;
                end
                m_pc = npc;
            end
        end
    end

    // Compare DUT outputs with the model mid-cycle, every cycle.
    initial forever begin
        @(negedge clk);
        begin
            logic [31:0] npc;
            bit          pred;
            bit          unused_alloc;
            int          unused_acnt;
            model_fetch(npc, pred, unused_alloc, unused_acnt);
            check("model.pc_o",     pc_o,           rst ? RESET_PC : npc);
            check("model.now_pc_o", now_pc_o,       rst ? RESET_PC : m_pc);
            check("model.predict",  32'(pred_o),    rst ? 32'd0 : 32'(pred));
        end
    end

    task automatic drive(input bit r, input logic [2:0] c, input logic [31:0] to, input bit h,
                         input logic [31:0] in, input bit rv, input logic [31:0] ra, input bit rt);
        rst = r; cause = c; jump_to = to; hold = h; inst = in; res_v = rv; res_a = ra; res_t = rt;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] e_pc, input logic [31:0] e_now,
                       input bit e_pred);
        @(negedge clk);
        check({nm, ".pc_o"},     pc_o,        e_pc);
        check({nm, ".now_pc_o"}, now_pc_o,    e_now);
        check({nm, ".predict"},  32'(pred_o), 32'(e_pred));
    endtask

    initial begin
        drive(1, 0, 0, 0, NOP, 0, 0, 0);
        lit("rst0", 32'h0, 32'h0, 0); cyc();
        lit("rst1", 32'h0, 32'h0, 0); cyc();
        drive(0, 0, 0, 0, NOP, 0, 0, 0);
        lit("seq0", 32'h4, 32'h0, 0); cyc();
        lit("seq1", 32'h8, 32'h4, 0); cyc();
        lit("seq2", 32'hC, 32'h8, 0); cyc();
        drive(0, 3, 32'h10, 0, NOP, 0, 0, 0);
        lit("seq3", 32'h10, 32'hC, 0); cyc();
        drive(0, 0, 0, 0, BEQ_P20, 0, 0, 0);
        lit("miss", 32'h14, 32'h10, 0); cyc();
        drive(0, 3, 32'h10, 0, NOP, 1, 32'h10, 1);
        lit("train1", 32'h10, 32'h14, 0); cyc();
        drive(0, 0, 0, 0, BEQ_P20, 0, 0, 0);
        lit("hit_taken", 32'h30, 32'h10, 1); cyc();
        repeat (3) begin
            drive(0, 3, 32'h10, 0, NOP, 1, 32'h10, 1); cyc();
        end
        drive(0, 3, 32'h10, 0, NOP, 1, 32'h10, 0); cyc();
        drive(0, 0, 0, 0, BEQ_P20, 0, 0, 0);
        lit("saturate", 32'h30, 32'h10, 1); cyc();
        drive(0, 3, 32'h10, 0, NOP, 1, 32'h10, 0); cyc();
        drive(0, 0, 0, 0, BEQ_P20, 0, 0, 0);
        lit("weak_nt", 32'h14, 32'h10, 0); cyc();
        drive(0, 4, 32'h100, 0, NOP, 1, 32'h10, 1);
        lit("flush", 32'h100, 32'h14, 0); cyc();
        drive(0, 3, 32'h10, 0, NOP, 1, 32'h10, 1);
        lit("post_flush", 32'h10, 32'h100, 0); cyc();
        drive(0, 0, 0, 0, BEQ_P20, 0, 0, 0);
        lit("flushed_miss", 32'h14, 32'h10, 0); cyc();
        drive(0, 3, 32'h40, 0, NOP, 0, 0, 0); cyc();
        drive(0, 0, 0, 1, NOP, 0, 0, 0);
        repeat (3) begin
            lit("hold", 32'h40, 32'h40, 0); cyc();
        end
        drive(0, 3, 32'h200, 1, NOP, 0, 0, 0);
        lit("hold_jump", 32'h200, 32'h40, 0); cyc();
        drive(0, 3, 32'h108, 0, NOP, 0, 0, 0);
        lit("redirect", 32'h108, 32'h200, 0); cyc();
        drive(0, 0, 0, 0, BNE_M8, 0, 0, 0);
`ifdef PC_BPU_BTFN_EN
        lit("backward_miss", 32'h100, 32'h108, 1); cyc();
`else
        lit("backward_miss", 32'h10C, 32'h108, 0); cyc();
`endif

        for (int n = 0; n < 3000; n++) begin
            int c;
            rst   = ($urandom_range(0, 99) == 0);
            c     = int'($urandom_range(0, 99));
            if (c < 80)      cause = 3'd0;
            else if (c < 96) cause = 3'($urandom_range(1, 3));
            else             cause = 3'($urandom_range(4, 7));
            jump_to = 32'($urandom_range(1, 12)) << 4;
            hold    = ($urandom_range(0, 9) == 0);
            inst    = $urandom;
            if ($urandom_range(0, 1) == 1) inst[6:0] = 7'h63;
            else if (inst[6:0] == 7'h63)   inst[0] = 1'b0;
            res_v = ($urandom_range(0, 2) != 0);
            res_a = 32'($urandom_range(1, 12)) << 4;
            res_t = 1'($urandom_range(0, 1));
            cyc();
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
